// File: rtl/lmx_pkg.sv
// Shared definitions for the LMX PLL SPI register loader.
package lmx_pkg;

  // One LMX register frame: {R/W=0, addr[6:0], data[15:0]}.
  localparam int LMX_WORD_W = 24;

  // Width of the register-table index / ROM address.
  localparam int LMX_IDX_W = 14;

  // Number of entries in the default LMX register table.
  localparam int LMX_N_REGS = 126;

  // Sequencer state encodings.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ADDR  = ST_ADDR,
    S_LOAD  = ST_LOAD,
    S_SHIFT = ST_SHIFT,
    S_GAP   = ST_GAP,
    S_DONE  = ST_DONE
  } lmx_state_t;

endpackage

// File: rtl/spi_tx24.sv
// 24-bit SPI frame transmitter: CLK_DIV divider, bit counter and shift
// register. Drives SCK (idle low), MOSI (MSB first) and CSB (active low).
//
// Handshake: 'load' is a single-cycle command; it is only issued while no
// frame is active. On the load edge the word is captured, CSB drops and
// MOSI presents bit 23. 'frame_done' is high during the last cycle of the
// frame (the final SCK high phase); on the following edge SCK falls, CSB
// rises and MOSI returns low, all together.
module spi_tx24
  import lmx_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [LMX_WORD_W-1:0] data,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  csb,
  output logic                  frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(LMX_WORD_W - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [4:0]            bit_cnt;
  logic [LMX_WORD_W-1:0] shreg;
  logic                  active;
  logic                  phase_end;

  // A half-period of SCK ends every CLK_DIV cycles while a frame is active.
  assign phase_end  = active && (div_cnt == DIV_LAST);
  assign frame_done = phase_end && sclk && (bit_cnt == BIT_LAST);

  // MOSI is the top of the shift register; the register is cleared between
  // frames so the line idles low.
  assign mosi = shreg[LMX_WORD_W-1];

  // Frame engine: SCK low phase, then high phase; data moves only when SCK
  // falls so it is stable across every rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      csb     <= 1'b1;
    end else if (load) begin
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= data;
      sclk    <= 1'b0;
      csb     <= 1'b0;
    end else if (active) begin
      if (phase_end) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else if (bit_cnt == BIT_LAST) begin
          // Last high phase over: SCK falls and CSB rises on the same edge.
          active <= 1'b0;
          sclk   <= 1'b0;
          csb    <= 1'b1;
          shreg  <= '0;
        end else begin
          sclk    <= 1'b0;
          bit_cnt <= bit_cnt + 5'd1;
          shreg   <= {shreg[LMX_WORD_W-2:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/lmx_spi_loader.sv
// LMX PLL register loader: walks the register-table ROM from index 0 to
// N_REGS-1 and sends each word as one 24-bit SPI frame, with CSB held high
// for CS_GAP cycles after every frame.
module lmx_spi_loader
  import lmx_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int N_REGS  = LMX_N_REGS,
  parameter int CS_GAP  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic [LMX_IDX_W-1:0]  o_reg_nr,
  input  logic [LMX_WORD_W-1:0] i_lmx_reg,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_csb,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [LMX_IDX_W-1:0] IDX_LAST = LMX_IDX_W'(N_REGS - 1);

  lmx_state_t       state;
  lmx_state_t       next_state;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_last;
  logic             last_idx;
  logic             tx_load;
  logic             tx_frame_done;

  assign gap_last = (gap_cnt == GAP_LAST);
  // The index counter stops at N_REGS-1, so it never wraps during a run.
  assign last_idx = (o_reg_nr == IDX_LAST);
  // LOAD is the cycle in which the registered ROM word is valid.
  assign tx_load  = (state == S_LOAD);

  spi_tx24 #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk        (i_clk),
    .rst        (i_rst),
    .load       (tx_load),
    .data       (i_lmx_reg),
    .sclk       (o_sclk),
    .mosi       (o_mosi),
    .csb        (o_csb),
    .frame_done (tx_frame_done)
  );

  // Sequencer state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: ADDR covers the ROM read latency, LOAD hands the word
  // to the transmitter, SHIFT waits for the frame, GAP spaces the frames.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (i_start) next_state = S_ADDR;
      S_ADDR:  next_state = S_LOAD;
      S_LOAD:  next_state = S_SHIFT;
      S_SHIFT: if (tx_frame_done) next_state = S_GAP;
      S_GAP: begin
        if (gap_last) begin
          next_state = last_idx ? S_DONE : S_ADDR;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Index counter, gap timer and registered status outputs. Status flags
  // are computed from the next state so they line up with the state itself.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_reg_nr <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      o_busy  <= (next_state != S_IDLE) && (next_state != S_DONE);
      o_done  <= (next_state == S_DONE);
      gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
      case (state)
        S_IDLE: if (i_start) o_reg_nr <= '0;
        S_GAP:  if (gap_last && !last_idx) o_reg_nr <= o_reg_nr + LMX_IDX_W'(1);
        S_DONE: o_reg_nr <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lmx_spi_loader.sv
// Bench for lmx_spi_loader: a default instance (CLK_DIV=4, CS_GAP=4,
// N_REGS=126) and a small one (CLK_DIV=1, CS_GAP=1, N_REGS=3), each fed by
// a registered ROM model. An SPI decoder logs every complete frame and its
// timing; the expected frames are simply the table entries in index order.
module tb_lmx_spi_loader;

  localparam int D_DIV  = 4;
  localparam int D_GAP  = 4;
  localparam int D_N    = 126;
  localparam int D_WORD = 2 + 48 * D_DIV + D_GAP;   // 198
  localparam int S_DIV  = 1;
  localparam int S_GAP  = 1;
  localparam int S_N    = 3;
  localparam int S_WORD = 2 + 48 * S_DIV + S_GAP;   // 51

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs and ROM models ----------------
  logic        d_rst = 1'b1, d_start = 1'b0;
  logic [13:0] d_reg_nr;
  logic [23:0] d_lmx_reg = '0;
  logic        d_sclk, d_mosi, d_csb, d_busy, d_done;
  logic [23:0] rom_mem [0:D_N-1];

  logic        s_rst = 1'b1, s_start = 1'b0;
  logic [13:0] s_reg_nr;
  logic [23:0] s_lmx_reg = '0;
  logic        s_sclk, s_mosi, s_csb, s_busy, s_done;
  logic [23:0] s_rom [0:S_N-1];

  lmx_spi_loader u_dut (
    .i_clk(clk), .i_rst(d_rst), .i_start(d_start), .o_reg_nr(d_reg_nr),
    .i_lmx_reg(d_lmx_reg), .o_sclk(d_sclk), .o_mosi(d_mosi), .o_csb(d_csb),
    .o_busy(d_busy), .o_done(d_done)
  );

  lmx_spi_loader #(.CLK_DIV(S_DIV), .N_REGS(S_N), .CS_GAP(S_GAP)) u_small (
    .i_clk(clk), .i_rst(s_rst), .i_start(s_start), .o_reg_nr(s_reg_nr),
    .i_lmx_reg(s_lmx_reg), .o_sclk(s_sclk), .o_mosi(s_mosi), .o_csb(s_csb),
    .o_busy(s_busy), .o_done(s_done)
  );

  // ROM returns the addressed word one cycle later.
  always @(posedge clk) begin
    d_lmx_reg <= (d_reg_nr < 14'(D_N)) ? rom_mem[d_reg_nr] : 24'h0;
    s_lmx_reg <= (s_reg_nr < 14'(S_N)) ? s_rom[s_reg_nr[1:0]] : 24'h0;
  end

  // ---------------- SPI decoder (on the selected instance) ----------------
  logic sel = 1'b0;
  logic mon_rst, mon_sclk, mon_mosi, mon_csb, mon_done;
  assign mon_rst  = sel ? s_rst  : d_rst;
  assign mon_sclk = sel ? s_sclk : d_sclk;
  assign mon_mosi = sel ? s_mosi : d_mosi;
  assign mon_csb  = sel ? s_csb  : d_csb;
  assign mon_done = sel ? s_done : d_done;

  logic [23:0] frm_q[$];
  int edg_q[$], low_q[$], setup_q[$], gap_q[$], fall_q[$], done_q[$];
  logic prev_csb = 1'b1, prev_sclk = 1'b0, in_frame = 1'b0, have_prev = 1'b0;
  logic [23:0] cur_bits = '0;
  int cur_edges = 0, cur_low = 0, cur_setup = 0, high_cnt = 0, viol = 0;

  always @(negedge clk) begin
    if (mon_rst) begin
      in_frame  = 1'b0;
      have_prev = 1'b0;
      high_cnt  = 0;
      prev_csb  = 1'b1;
      prev_sclk = 1'b0;
    end else begin
      if (prev_csb && !mon_csb) begin
        in_frame = 1'b1; cur_bits = '0; cur_edges = 0; cur_low = 0; cur_setup = -1;
        fall_q.push_back(cyc);
        if (have_prev) gap_q.push_back(high_cnt);
      end
      if (!mon_csb && in_frame) begin
        cur_low++;
        if (!prev_sclk && mon_sclk) begin
          if (cur_edges == 0) cur_setup = cur_low - 1;
          cur_bits = {cur_bits[22:0], mon_mosi};
          cur_edges++;
        end
      end
      if (!prev_csb && mon_csb && in_frame) begin
        frm_q.push_back(cur_bits);
        edg_q.push_back(cur_edges);
        low_q.push_back(cur_low);
        setup_q.push_back(cur_setup);
        in_frame = 1'b0; have_prev = 1'b1; high_cnt = 0;
      end
      if (mon_csb) begin
        high_cnt++;
        if (mon_sclk || mon_mosi) viol++;
      end
      if (mon_done) done_q.push_back(cyc);
      prev_csb  = mon_csb;
      prev_sclk = mon_sclk;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_d();
    @(posedge clk); #1 d_rst = 1'b1; d_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 d_rst = 1'b0;
  endtask

  task automatic start_d(output int c0);
    @(posedge clk); #1 d_start = 1'b1;
    @(posedge clk); #1 c0 = cyc; d_start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (frm_q.size() >= target) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_done(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done_q.size() >= target) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk); #1 d_rst = 1'b1;
    #1;
    n_checks++;
    if (d_csb !== 1'b1 || d_sclk !== 1'b0 || d_mosi !== 1'b0 || d_reg_nr !== 14'd0 ||
        d_busy !== 1'b0 || d_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: csb=%b sclk=%b mosi=%b reg_nr=%0d busy=%b done=%b, want 1 0 0 0 0 0",
               d_csb, d_sclk, d_mosi, d_reg_nr, d_busy, d_done);
    end
    repeat (2) @(posedge clk);
    #1 d_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if (d_csb !== 1'b1 || d_sclk !== 1'b0 || d_busy !== 1'b0 || d_reg_nr !== 14'd0) begin
        n_fail++;
        $display("FAIL idle_cycle_%0d: csb=%b sclk=%b busy=%b reg_nr=%0d, want 1 0 0 0",
                 i, d_csb, d_sclk, d_busy, d_reg_nr);
      end
    end
  endtask

  task automatic test_first_frame();
    int c0, fb, xb;
    bit ok;
    logic [23:0] want;
    want = 24'b0111_1101_0010_0010_1000_1000;
    for (int k = 0; k < D_N; k++) rom_mem[k] = {1'b0, 23'($urandom())};
    rom_mem[0] = 24'h7D2288;
    reset_d();
    fb = frm_q.size(); xb = fall_q.size();
    start_d(c0);
    wait_frames(fb + 1, 500, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL first_frame_timeout: no frame, want 1 frame"); end
    if (ok) begin
      n_checks++;
      if (frm_q[fb] !== want) begin
        n_fail++; $display("FAIL first_frame_bits: got %b want %b", frm_q[fb], want);
      end
      n_checks++;
      if (edg_q[fb] != 24) begin
        n_fail++; $display("FAIL first_frame_edges: got %0d want 24", edg_q[fb]);
      end
      n_checks++;
      if (low_q[fb] != 48 * D_DIV) begin
        n_fail++; $display("FAIL first_frame_csb_low: got %0d want %0d", low_q[fb], 48 * D_DIV);
      end
      n_checks++;
      if (setup_q[fb] != D_DIV) begin
        n_fail++; $display("FAIL first_frame_setup: got %0d want %0d", setup_q[fb], D_DIV);
      end
      // CSB is low in the third cycle after the sampling edge (ADDR, LOAD, SHIFT).
      n_checks++;
      if (fall_q[xb] - c0 != 2) begin
        n_fail++; $display("FAIL first_csb_fall: got +%0d want +2", fall_q[xb] - c0);
      end
    end
    n_checks++;
    if (d_busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_run: got %b want 1", d_busy); end
    reset_d();
  endtask

  // Runs one full default-config load and checks every frame and timing.
  task automatic run_full(input string tag, input bit second_start);
    int c0, fb, gb, xb, db, vb, nf;
    bit ok;
    reset_d();
    fb = frm_q.size(); gb = gap_q.size(); xb = fall_q.size(); db = done_q.size(); vb = viol;
    start_d(c0);
    if (second_start) begin
      repeat (499) @(posedge clk);
      #1 d_start = 1'b1;
      @(posedge clk); #1 d_start = 1'b0;
    end
    wait_done(db + 1, 26000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_done_timeout: no done pulse, want one", tag); end
    repeat (300) @(posedge clk);
    #2;
    nf = frm_q.size() - fb;
    n_checks++;
    if (nf != D_N) begin n_fail++; $display("FAIL %s_frame_count: got %0d want %0d", tag, nf, D_N); end
    for (int k = 0; k < nf && k < D_N; k++) begin
      n_checks++;
      if (frm_q[fb + k] !== rom_mem[k]) begin
        n_fail++; $display("FAIL %s_frame_%0d: got %h want %h", tag, k, frm_q[fb + k], rom_mem[k]);
      end
      n_checks++;
      if (edg_q[fb + k] != 24 || low_q[fb + k] != 48 * D_DIV || setup_q[fb + k] != D_DIV) begin
        n_fail++;
        $display("FAIL %s_frame_%0d_timing: edges=%0d low=%0d setup=%0d, want 24 %0d %0d",
                 tag, k, edg_q[fb + k], low_q[fb + k], setup_q[fb + k], 48 * D_DIV, D_DIV);
      end
    end
    // Between frames CSB stays high for the gap plus the ADDR and LOAD cycles.
    n_checks++;
    if (gap_q.size() - gb != D_N - 1) begin
      n_fail++; $display("FAIL %s_gap_count: got %0d want %0d", tag, gap_q.size() - gb, D_N - 1);
    end
    for (int k = gb; k < gap_q.size(); k++) begin
      n_checks++;
      if (gap_q[k] != D_GAP + 2) begin
        n_fail++; $display("FAIL %s_gap_%0d: got %0d want %0d", tag, k - gb, gap_q[k], D_GAP + 2);
      end
    end
    for (int k = xb; k + 1 < fall_q.size(); k++) begin
      n_checks++;
      if (fall_q[k + 1] - fall_q[k] != D_WORD) begin
        n_fail++; $display("FAIL %s_word_period_%0d: got %0d want %0d", tag, k - xb,
                           fall_q[k + 1] - fall_q[k], D_WORD);
      end
    end
    n_checks++;
    if (done_q.size() - db != 1) begin
      n_fail++; $display("FAIL %s_done_pulses: got %0d want 1", tag, done_q.size() - db);
    end
    if (done_q.size() > db) begin
      n_checks++;
      if (done_q[db] - c0 != D_N * D_WORD) begin
        n_fail++; $display("FAIL %s_done_latency: got %0d want %0d", tag, done_q[db] - c0, D_N * D_WORD);
      end
    end
    if (nf == D_N) begin
      n_checks++;
      if (frm_q[fb + D_N - 1][22:16] !== 7'(rom_mem[D_N - 1][22:16])) begin
        n_fail++; $display("FAIL %s_last_addr: got %0d want %0d", tag,
                           frm_q[fb + D_N - 1][22:16], rom_mem[D_N - 1][22:16]);
      end
    end
    n_checks++;
    if (viol != vb) begin n_fail++; $display("FAIL %s_idle_lines: got %0d violations want 0", tag, viol - vb); end
    n_checks++;
    if (d_busy !== 1'b0 || d_reg_nr !== 14'd0 || d_csb !== 1'b1) begin
      n_fail++; $display("FAIL %s_after_done: busy=%b reg_nr=%0d csb=%b want 0 0 1", tag, d_busy, d_reg_nr, d_csb);
    end
  endtask

  task automatic test_full_run();
    for (int k = 0; k < D_N; k++) rom_mem[k] = {1'b0, 7'(125 - k), 16'hA500 + 16'(k)};
    run_full("full", 1'b0);
    n_checks++;
    if (rom_mem[D_N - 1][22:16] !== 7'd0) begin
      n_fail++; $display("FAIL full_table_last_addr: got %0d want 0", rom_mem[D_N - 1][22:16]);
    end
  endtask

  task automatic test_start_ignored();
    for (int k = 0; k < D_N; k++) rom_mem[k] = {1'b0, 23'($urandom())};
    run_full("restart", 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int c0, c1, fb, xb;
    bit ok;
    for (int k = 0; k < D_N; k++) rom_mem[k] = {1'b0, 23'($urandom())};
    reset_d();
    fb = frm_q.size();
    start_d(c0);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (frm_q.size() - fb == 10 && in_frame && cur_edges == 7) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midreset_reach: word 10 bit 7 not reached, want reached"); end
    @(posedge clk); #1 d_rst = 1'b1;
    #1;
    n_checks++;
    if (d_csb !== 1'b1) begin n_fail++; $display("FAIL midreset_csb: got %b want 1", d_csb); end
    n_checks++;
    if (d_sclk !== 1'b0 || d_mosi !== 1'b0 || d_reg_nr !== 14'd0 || d_busy !== 1'b0 || d_done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: sclk=%b mosi=%b reg_nr=%0d busy=%b done=%b want 0 0 0 0 0",
                         d_sclk, d_mosi, d_reg_nr, d_busy, d_done);
    end
    repeat (3) @(posedge clk);
    #1 d_rst = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    n_checks++;
    if (frm_q.size() - fb != 10) begin
      n_fail++; $display("FAIL midreset_partial: got %0d frames want 10", frm_q.size() - fb);
    end
    fb = frm_q.size(); xb = fall_q.size();
    start_d(c1);
    wait_frames(fb + 2, 600, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midreset_restart_timeout: frames missing, want 2"); end
    if (ok) begin
      n_checks++;
      if (frm_q[fb] !== rom_mem[0] || frm_q[fb + 1] !== rom_mem[1]) begin
        n_fail++; $display("FAIL midreset_restart_frames: got %h %h want %h %h",
                           frm_q[fb], frm_q[fb + 1], rom_mem[0], rom_mem[1]);
      end
      n_checks++;
      if (fall_q[xb] - c1 != 2) begin
        n_fail++; $display("FAIL midreset_restart_fall: got +%0d want +2", fall_q[xb] - c1);
      end
    end
    reset_d();
  endtask

  task automatic test_small_config();
    int c0, fb, gb, xb, db;
    bit ok;
    for (int k = 0; k < S_N; k++) s_rom[k] = {1'b0, 23'($urandom())};
    @(posedge clk); #1 d_rst = 1'b1; s_rst = 1'b1;
    @(posedge clk); #1 sel = 1'b1;
    repeat (3) @(posedge clk);
    #1 s_rst = 1'b0;
    @(posedge clk); #2;
    fb = frm_q.size(); gb = gap_q.size(); xb = fall_q.size(); db = done_q.size();
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 c0 = cyc; s_start = 1'b0;
    wait_done(db + 1, 400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL small_done_timeout: no done pulse, want one"); end
    repeat (20) @(posedge clk);
    #2;
    n_checks++;
    if (frm_q.size() - fb != S_N) begin
      n_fail++; $display("FAIL small_frame_count: got %0d want %0d", frm_q.size() - fb, S_N);
    end
    for (int k = 0; k < S_N && fb + k < frm_q.size(); k++) begin
      n_checks++;
      if (frm_q[fb + k] !== s_rom[k] || edg_q[fb + k] != 24 || low_q[fb + k] != 48 || setup_q[fb + k] != 1) begin
        n_fail++; $display("FAIL small_frame_%0d: got %h edges=%0d low=%0d setup=%0d want %h 24 48 1",
                           k, frm_q[fb + k], edg_q[fb + k], low_q[fb + k], setup_q[fb + k], s_rom[k]);
      end
    end
    for (int k = gb; k < gap_q.size(); k++) begin
      n_checks++;
      if (gap_q[k] != S_GAP + 2) begin
        n_fail++; $display("FAIL small_gap_%0d: got %0d want %0d", k - gb, gap_q[k], S_GAP + 2);
      end
    end
    for (int k = xb; k + 1 < fall_q.size(); k++) begin
      n_checks++;
      if (fall_q[k + 1] - fall_q[k] != S_WORD) begin
        n_fail++; $display("FAIL small_word_period_%0d: got %0d want %0d", k - xb, fall_q[k + 1] - fall_q[k], S_WORD);
      end
    end
    n_checks++;
    if (done_q.size() - db != 1) begin
      n_fail++; $display("FAIL small_done_pulses: got %0d want 1", done_q.size() - db);
    end
    if (done_q.size() > db) begin
      n_checks++;
      if (done_q[db] - c0 != S_N * S_WORD) begin
        n_fail++; $display("FAIL small_done_latency: got %0d want %0d", done_q[db] - c0, S_N * S_WORD);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < D_N; k++) rom_mem[k] = '0;
    for (int k = 0; k < S_N; k++) s_rom[k] = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_first_frame();
    test_full_run();
    test_start_ignored();
    test_reset_mid_frame();
    test_small_config();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
